// File: rtl/game_round_controller.sv
`timescale 1ns/1ps
// game_round_controller: runs the note-memory game round by round (clear, load song, start, wait).
// Define GAME_SCORE_EN to add a saturating score output.
module game_round_controller #(
  parameter int unsigned NUM_ROUNDS    = 4,
  parameter int unsigned TICK_MAX      = 5000000,
  parameter int unsigned TIMEOUT_TICKS = 600,
  parameter int unsigned GAP_TICKS     = 20,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        game_end,
  output logic [31:0] song_data,
  output logic        write_enable,
  output logic        game_start,
  output logic        game_reset,
  output logic [2:0]  round,
  output logic        busy,
  output logic        all_clear,
  output logic        timeout_flag
`ifdef GAME_SCORE_EN
  ,
  output logic [7:0]  score
`endif
);

  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int PLAY_W   = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam int GAP_W    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_MAX - 1);
  localparam logic [PLAY_W-1:0]   TIMEOUT_VAL = PLAY_W'(TIMEOUT_TICKS);
  localparam logic [GAP_W-1:0]    GAP_VAL     = GAP_W'(GAP_TICKS);
  localparam logic [SETTLE_W-1:0] SETTLE_VAL  = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [2:0]          LAST_ROUND  = 3'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, ARM, PLAY, WAIT_GAP, DONE, FAIL
  } state_t;

  state_t state, next_state;

  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic                start_prev, end_prev;
  logic                start_edge, end_edge;
  logic [SETTLE_W-1:0] clear_cnt;
  logic                load_phase;
  logic [PLAY_W-1:0]   play_timer;
  logic [GAP_W-1:0]    gap_cnt;
  logic                game_reset_d, write_enable_d, game_start_d;
  logic                busy_d, all_clear_d, timeout_d;
  logic                new_game;

  function automatic logic [31:0] song_for(input logic [2:0] r);
    case (r)
      3'd0:    song_for = 32'h0123_4567;
      3'd1:    song_for = 32'h0765_4321;
      3'd2:    song_for = 32'h0246_1357;
      3'd3:    song_for = 32'h0011_2233;
      default: song_for = 32'h0321_0321;
    endcase
  endfunction

  assign tick       = (tick_cnt == TICK_LAST);
  assign start_edge = start_btn & ~start_prev;
  assign end_edge   = game_end & ~end_prev;
  assign new_game   = ((state == IDLE) || (state == DONE)) && (next_state == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt   <= '0;
      start_prev <= 1'b0;
      end_prev   <= 1'b0;
    end else begin
      tick_cnt   <= tick ? '0 : tick_cnt + TICK_W'(1);
      start_prev <= start_btn;
      end_prev   <= game_end;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A game_end edge takes priority over a timeout landing on the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start_edge) next_state = CLEAR;
      CLEAR:    if (clear_cnt == SETTLE_VAL) next_state = LOAD;
      LOAD:     if (load_phase) next_state = ARM;
      ARM:      next_state = PLAY;
      PLAY: begin
        if (end_edge)                       next_state = (round == LAST_ROUND) ? DONE : WAIT_GAP;
        else if (play_timer == TIMEOUT_VAL) next_state = FAIL;
      end
      WAIT_GAP: if (gap_cnt == GAP_VAL) next_state = CLEAR;
      DONE:     if (start_edge) next_state = CLEAR;
      FAIL:     if (start_edge) next_state = CLEAR;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are computed one cycle early and registered, so they line up with the state.
  always_comb begin
    game_reset_d   = (next_state == CLEAR) && (state != CLEAR);
    write_enable_d = (state == LOAD) && !load_phase;
    game_start_d   = (next_state == ARM);
    busy_d         = (next_state == CLEAR) || (next_state == LOAD) || (next_state == ARM) ||
                     (next_state == PLAY) || (next_state == WAIT_GAP);
    all_clear_d    = (next_state == DONE);
    timeout_d      = (next_state == FAIL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      game_reset   <= 1'b0;
      write_enable <= 1'b0;
      game_start   <= 1'b0;
      busy         <= 1'b0;
      all_clear    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      game_reset   <= game_reset_d;
      write_enable <= write_enable_d;
      game_start   <= game_start_d;
      busy         <= busy_d;
      all_clear    <= all_clear_d;
      timeout_flag <= timeout_d;
    end
  end

  // Phase counters, round index and the song word handed to the game module.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_cnt  <= '0;
      load_phase <= 1'b0;
      play_timer <= '0;
      gap_cnt    <= '0;
      round      <= 3'd0;
      song_data  <= 32'd0;
    end else begin
      clear_cnt  <= (state == CLEAR) ? clear_cnt + SETTLE_W'(1) : '0;
      load_phase <= (state == LOAD) && !load_phase;

      if (state == ARM)
        play_timer <= '0;
      else if ((state == PLAY) && tick && (play_timer != TIMEOUT_VAL))
        play_timer <= play_timer + PLAY_W'(1);

      if (state != WAIT_GAP)
        gap_cnt <= '0;
      else if (tick && (gap_cnt != GAP_VAL))
        gap_cnt <= gap_cnt + GAP_W'(1);

      if (new_game)
        round <= 3'd0;
      else if ((state == WAIT_GAP) && (next_state == CLEAR) && (round != LAST_ROUND))
        round <= round + 3'd1;

      if ((next_state == LOAD) && (state != LOAD))
        song_data <= song_for(round);
    end
  end

`ifdef GAME_SCORE_EN
  localparam logic [PLAY_W-1:0] BONUS_LIMIT = PLAY_W'(TIMEOUT_TICKS / 2);

  logic [8:0] score_sum;

  assign score_sum = {1'b0, score} + ((play_timer < BONUS_LIMIT) ? 9'd2 : 9'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      score <= 8'd0;
    else if (new_game)
      score <= 8'd0;
    else if ((state == PLAY) && end_edge)
      score <= score_sum[8] ? 8'hFF : score_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_game_round_controller.sv
`timescale 1ns/1ps
// tb_game_round_controller: randomized scoreboard bench; expected events come from a cycle-level
// model of the game rules (tick phase, settle/load latency, timeouts, gaps).
module tb_game_round_controller;

  localparam int TM = 4;
  localparam int TO = 10;
  localparam int GT = 2;
  localparam int SC = 4;
  localparam int NR = 4;

  localparam int K_NORMAL  = 0;
  localparam int K_TIE     = 1;
  localparam int K_TIMEOUT = 2;
  localparam int K_RESET   = 3;

  localparam int EV_RESET = 0;
  localparam int EV_WE    = 1;
  localparam int EV_START = 2;
  localparam int EV_TO    = 3;
  localparam int EV_DONE  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn;
  logic        game_end;
  logic [31:0] song_data;
  logic        write_enable;
  logic        game_start;
  logic        game_reset;
  logic [2:0]  round;
  logic        busy;
  logic        all_clear;
  logic        timeout_flag;
`ifdef GAME_SCORE_EN
  logic [7:0]  score;
`endif

  typedef struct {
    int          kind;
    int          at;
    int          rnd;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks;
  int  errors;
  int  cyc;
  int  exp_score;
  logic prev_to, prev_ac;

  game_round_controller #(
    .NUM_ROUNDS(NR), .TICK_MAX(TM), .TIMEOUT_TICKS(TO), .GAP_TICKS(GT), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .game_end(game_end),
    .song_data(song_data), .write_enable(write_enable), .game_start(game_start),
    .game_reset(game_reset), .round(round), .busy(busy), .all_clear(all_clear),
    .timeout_flag(timeout_flag)
`ifdef GAME_SCORE_EN
    , .score(score)
`endif
  );

  always #5 clk = ~clk;

  // Cycle index as seen at each falling edge; index 0 is the reset-release cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [31:0] song_ref(input int r);
    case (r)
      0:       return 32'h0123_4567;
      1:       return 32'h0765_4321;
      2:       return 32'h0246_1357;
      3:       return 32'h0011_2233;
      default: return 32'h0321_0321;
    endcase
  endfunction

  function automatic int nth_tick(input int from, input int n);
    int first;
    first = from + (((TM - 1) - (from % TM)) + TM) % TM;
    return first + (n - 1) * TM;
  endfunction

  function automatic int ticks_between(input int lo, input int hi);
    int n;
    n = 0;
    for (int j = lo; j <= hi; j++) if (j % TM == TM - 1) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic checkScore(input string name);
`ifdef GAME_SCORE_EN
    checkOutput(name, 32'(score), 32'(exp_score));
`endif
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_song_data"}, song_data, 0);
    checkOutput({tag, "_write_enable"}, 32'(write_enable), 0);
    checkOutput({tag, "_game_start"}, 32'(game_start), 0);
    checkOutput({tag, "_game_reset"}, 32'(game_reset), 0);
    checkOutput({tag, "_round"}, 32'(round), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_all_clear"}, 32'(all_clear), 0);
    checkOutput({tag, "_timeout_flag"}, 32'(timeout_flag), 0);
    checkScore({tag, "_score"});
  endtask

  task automatic push(input int kind, input int at, input int rnd, input logic [31:0] data);
    ev_t ev;
    ev.kind = kind;
    ev.at   = at;
    ev.rnd  = rnd;
    ev.data = data;
    exp_q.push_back(ev);
  endtask

  // Round starting with its game_reset pulse at cycle c: load and start follow at fixed latency.
  task automatic pushRound(input int c, input int rnd);
    push(EV_RESET, c, rnd, 0);
    push(EV_WE, c + SC + 2, rnd, song_ref(rnd));
    push(EV_START, c + SC + 3, rnd, 0);
  endtask

  task automatic popCompare(input int kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event kind=%0d at cycle %0d round=%0d, expected none", kind, cyc, round);
    end else begin
      ev = exp_q.pop_front();
      checkOutput("event_kind", 32'(kind), 32'(ev.kind));
      checkOutput("event_cycle", 32'(cyc), 32'(ev.at));
      checkOutput("event_round", 32'(round), 32'(ev.rnd));
      if (kind == EV_WE) checkOutput("song_data", song_data, ev.data);
      if (kind <= EV_START) checkOutput("busy_on_pulse", 32'(busy), 1);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_to <= 1'b0;
      prev_ac <= 1'b0;
    end else begin
      if (game_reset | write_enable | game_start)
        checkOutput("pulse_overlap", 32'($countones({game_reset, write_enable, game_start})), 1);
      if (game_reset)                popCompare(EV_RESET);
      if (write_enable)              popCompare(EV_WE);
      if (game_start)                popCompare(EV_START);
      if (timeout_flag && !prev_to)  popCompare(EV_TO);
      if (all_clear && !prev_ac)     popCompare(EV_DONE);
      prev_to <= timeout_flag;
      prev_ac <= all_clear;
    end
  end

  task automatic waitUntil(input int idx);
    while (cyc < idx) @(negedge clk);
  endtask

  task automatic applyStimulus(input int at, input bit is_start);
    waitUntil(at);
    if (is_start) start_btn = 1'b1;
    else          game_end  = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    game_end  = 1'b0;
  endtask

  task automatic startGame(input int rnd, input bit fresh, output int c);
    int s;
    s = cyc + 1;
    c = s + 1;
    if (fresh) exp_score = 0;
    pushRound(c, rnd);
    applyStimulus(s, 1'b1);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    exp_score = 0;
    @(negedge clk);
    checkAllZero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    checkAllZero("after_reset");
  endtask

  task automatic runRound(input int c, input int rnd, input int kind, output int next_c);
    int a, j10, g;
    a   = c + SC + 3;
    j10 = nth_tick(a + 1, TO);
    next_c = 0;
    applyStimulus(c + 1, 1'b1);
    applyStimulus(a + 1, 1'b1);
    if (kind == K_TIMEOUT) begin
      push(EV_TO, j10 + 2, rnd, 0);
      waitUntil(j10 + 2);
      checkOutput("timeout_flag", 32'(timeout_flag), 1);
      checkOutput("busy_in_fail", 32'(busy), 0);
      checkOutput("round_in_fail", 32'(round), 32'(rnd));
      checkScore("score_in_fail");
      next_c = j10 + 2;
    end else if (kind == K_RESET) begin
      waitUntil(a + 6);
      doReset();
    end else begin
      g = (kind == K_TIE) ? j10 + 1 : int'($urandom_range(j10 + 1, a + 3));
      exp_score += (ticks_between(a + 1, g - 1) < TO / 2) ? 2 : 1;
      if (exp_score > 255) exp_score = 255;
      if (rnd == NR - 1) begin
        push(EV_DONE, g + 1, rnd, 0);
        applyStimulus(g, 1'b0);
        waitUntil(g + 1);
        checkOutput("all_clear", 32'(all_clear), 1);
        checkOutput("busy_in_done", 32'(busy), 0);
        checkOutput("timeout_in_done", 32'(timeout_flag), 0);
        checkScore("score_in_done");
        next_c = g + 1;
      end else begin
        next_c = nth_tick(g + 1, GT) + 2;
        pushRound(next_c, rnd + 1);
        applyStimulus(g, 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d, expected finish earlier", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    checks = 0;
    errors = 0;
    exp_score = 0;
    reset = 1'b1;
    start_btn = 1'b0;
    game_end = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    @(negedge clk);
    checkAllZero("release");

    startGame(0, 1'b1, c);
    for (int r = 0; r < NR; r++) runRound(c, r, (r == 1) ? K_TIE : K_NORMAL, c);

    startGame(0, 1'b1, c);
    runRound(c, 0, K_TIMEOUT, c);
    startGame(0, 1'b0, c);
    checkOutput("timeout_cleared_on_retry", 32'(timeout_flag), 0);
    runRound(c, 0, K_TIE, c);
    runRound(c, 1, K_NORMAL, c);
    runRound(c, 2, K_RESET, c);

    startGame(0, 1'b1, c);
    for (int r = 0; r < NR; r++) runRound(c, r, (r == NR - 1) ? K_TIE : K_NORMAL, c);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    while (exp_q.size() > 0) begin
      ev_t ev;
      ev = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_event kind=%0d: got none, expected at cycle %0d", ev.kind, ev.at);
    end
    $display("[TB] final modelled score %0d", exp_score);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
